// File: rtl/control_unit.sv
// Hardwired Moore control unit for DataPath: fetches, dispatches on the latched opcode and
// sequences T0..T7 per instruction class, halting on the halt opcode or an external stop.
module control_unit #(
    parameter int MEM_WAIT = 1
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        con_ff,
    input  logic        stop,
    output logic        PC_out,
    output logic        ZLow_out,
    output logic        ZHigh_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        C_out,
    output logic        MDR_out,
    output logic        in_port_out,
    output logic        MAR_enable,
    output logic        Z_enable,
    output logic        PC_enable,
    output logic        MDR_enable,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic        IncPC,
    output logic        Read,
    output logic        RAM_write_enable,
    output logic        out_port_enable,
    output logic        con_in,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        R_in,
    output logic        R_out,
    output logic        BA_out,
    output logic [4:0]  opcode,
    output logic        run,
    output logic [3:0]  state_dbg
);
    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state, state_next;
    logic [4:0] op;
    logic [2:0] wait_cnt;
    logic       br_taken;
    logic       ir_unused;

    // Only the opcode field steers control; the operand bits belong to DataPath.
    assign ir_unused = ^IR[26:0];
    assign state_dbg = state;

    logic cls_alu_r, cls_alu_i, cls_ldi, cls_ld, cls_st, cls_br;
    logic cls_jr, cls_in, cls_out, cls_mfhi, cls_mflo, cls_halt;
    assign cls_alu_r = (op >= 5'd3) && (op <= 5'd11);
    assign cls_alu_i = (op >= 5'd12) && (op <= 5'd14);
    assign cls_ldi   = (op == 5'd1);
    assign cls_ld    = (op == 5'd0);
    assign cls_st    = (op == 5'd2);
    assign cls_br    = (op == 5'd19);
    assign cls_jr    = (op == 5'd20);
    assign cls_in    = (op == 5'd22);
    assign cls_out   = (op == 5'd23);
    assign cls_mfhi  = (op == 5'd24);
    assign cls_mflo  = (op == 5'd25);
    assign cls_halt  = (op == 5'd27);

    logic mem_wait, wait_done, last_step;
    assign mem_wait  = (state == S_T1) || ((state == S_T6) && cls_ld);
    assign wait_done = (wait_cnt == 3'(MEM_WAIT - 1));

    always_comb begin
        last_step = 1'b0;
        case (state)
            S_T3:    last_step = !(cls_alu_r || cls_alu_i || cls_ldi || cls_ld ||
                                   cls_st || cls_br || cls_halt);
            S_T5:    last_step = cls_alu_r || cls_alu_i || cls_ldi;
            S_T6:    last_step = cls_br;
            S_T7:    last_step = 1'b1;
            default: last_step = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            state    <= S_RST;
            op       <= 5'd0;
            wait_cnt <= 3'd0;
            br_taken <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= (mem_wait && !wait_done) ? wait_cnt + 3'd1 : 3'd0;
            // IR must already hold the fetched word on the edge that closes T2.
            if (state == S_T2) op <= IR[31:27];
            if (state == S_T5) br_taken <= con_ff;
        end
    end

    always_comb begin
        state_next = state;
        if (last_step) begin
            state_next = stop ? S_HALT : S_T0;
        end else begin
            case (state)
                S_RST:   state_next = S_T0;
                S_T0:    state_next = S_T1;
                S_T1:    state_next = wait_done ? S_T2 : S_T1;
                S_T2:    state_next = S_T3;
                S_T3:    state_next = cls_halt ? S_HALT : S_T4;
                S_T4:    state_next = S_T5;
                S_T5:    state_next = S_T6;
                S_T6:    state_next = (cls_ld && !wait_done) ? S_T6 : S_T7;
                S_HALT:  state_next = S_HALT;
                default: state_next = S_RST;
            endcase
        end
    end

    always_comb begin
        {PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out} = 8'd0;
        {MAR_enable, Z_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable} = 8'd0;
        {IncPC, Read, RAM_write_enable, out_port_enable, con_in} = 5'd0;
        {Gra, Grb, Grc, R_in, R_out, BA_out} = 6'd0;
        opcode = 5'd0;
        run    = (state != S_RST) && (state != S_HALT);
        case (state)
            S_T0: {PC_out, MAR_enable, IncPC, PC_enable} = 4'hf;
            S_T1: {Read, MDR_enable} = 2'b11;
            S_T2: {MDR_out, IR_enable} = 2'b11;
            S_T3: begin
                if (cls_alu_r || cls_alu_i)            {Grb, R_out, Y_enable} = 3'b111;
                else if (cls_ldi || cls_ld || cls_st)  {Grb, BA_out, Y_enable} = 3'b111;
                else if (cls_br)                       {Gra, R_out, con_in} = 3'b111;
                else if (cls_jr)                       {Gra, R_out, PC_enable} = 3'b111;
                else if (cls_in)                       {in_port_out, Gra, R_in} = 3'b111;
                else if (cls_out)                      {Gra, R_out, out_port_enable} = 3'b111;
                else if (cls_mfhi)                     {HI_out, Gra, R_in} = 3'b111;
                else if (cls_mflo)                     {LO_out, Gra, R_in} = 3'b111;
            end
            S_T4: begin
                if (cls_alu_r) begin
                    {Grc, R_out, Z_enable} = 3'b111;
                    opcode = op;
                end else if (cls_alu_i) begin
                    {C_out, Z_enable} = 2'b11;
                    opcode = op;
                end else if (cls_ldi || cls_ld || cls_st) begin
                    {C_out, Z_enable} = 2'b11;
                    opcode = 5'd3;
                end else if (cls_br) begin
                    {PC_out, Y_enable} = 2'b11;
                end
            end
            S_T5: begin
                if (cls_alu_r || cls_alu_i || cls_ldi) {ZLow_out, Gra, R_in} = 3'b111;
                else if (cls_ld || cls_st)             {ZLow_out, MAR_enable} = 2'b11;
                else if (cls_br) begin
                    {C_out, Z_enable} = 2'b11;
                    opcode = 5'd19;
                end
            end
            S_T6: begin
                if (cls_ld)                    {Read, MDR_enable} = 2'b11;
                else if (cls_st)               {Gra, R_out, MDR_enable} = 3'b111;
                else if (cls_br && br_taken)   {ZLow_out, PC_enable} = 2'b11;
            end
            S_T7: begin
                if (cls_ld)      {MDR_out, Gra, R_in} = 3'b111;
                else if (cls_st) RAM_write_enable = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a per-class reference table expands each instruction into its cycle-by-cycle
// control vectors, which a negedge monitor pops and compares against the DUT.
module tb_control_unit;
    localparam int MW = 3;

    logic        Clock = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] IR = '0;
    logic        con_ff = 1'b0;
    logic        stop = 1'b0;
    logic PC_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, MDR_out, in_port_out;
    logic MAR_enable, Z_enable, PC_enable, MDR_enable, IR_enable, Y_enable, HI_enable, LO_enable;
    logic IncPC, Read, RAM_write_enable, out_port_enable, con_in;
    logic Gra, Grb, Grc, R_in, R_out, BA_out, run;
    logic [4:0] opcode;
    logic [3:0] state_dbg;

    control_unit #(.MEM_WAIT(MW)) dut (
        .Clock(Clock), .clr(clr), .IR(IR), .con_ff(con_ff), .stop(stop),
        .PC_out(PC_out), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out), .HI_out(HI_out),
        .LO_out(LO_out), .C_out(C_out), .MDR_out(MDR_out), .in_port_out(in_port_out),
        .MAR_enable(MAR_enable), .Z_enable(Z_enable), .PC_enable(PC_enable),
        .MDR_enable(MDR_enable), .IR_enable(IR_enable), .Y_enable(Y_enable),
        .HI_enable(HI_enable), .LO_enable(LO_enable), .IncPC(IncPC), .Read(Read),
        .RAM_write_enable(RAM_write_enable), .out_port_enable(out_port_enable),
        .con_in(con_in), .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out),
        .BA_out(BA_out), .opcode(opcode), .run(run), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 Clock = ~Clock;

    logic [32:0] dut_vec;
    assign dut_vec = {run, opcode, BA_out, R_out, R_in, Grc, Grb, Gra,
                      con_in, out_port_enable, RAM_write_enable, Read, IncPC,
                      LO_enable, HI_enable, Y_enable, IR_enable, MDR_enable, PC_enable, Z_enable, MAR_enable,
                      in_port_out, MDR_out, C_out, LO_out, HI_out, ZHigh_out, ZLow_out, PC_out};

    localparam logic [32:0] M_PC_OUT  = 33'd1 << 0;
    localparam logic [32:0] M_ZLOW    = 33'd1 << 1;
    localparam logic [32:0] M_HI_OUT  = 33'd1 << 3;
    localparam logic [32:0] M_LO_OUT  = 33'd1 << 4;
    localparam logic [32:0] M_C_OUT   = 33'd1 << 5;
    localparam logic [32:0] M_MDR_OUT = 33'd1 << 6;
    localparam logic [32:0] M_INPORT  = 33'd1 << 7;
    localparam logic [32:0] M_MAR_EN  = 33'd1 << 8;
    localparam logic [32:0] M_Z_EN    = 33'd1 << 9;
    localparam logic [32:0] M_PC_EN   = 33'd1 << 10;
    localparam logic [32:0] M_MDR_EN  = 33'd1 << 11;
    localparam logic [32:0] M_IR_EN   = 33'd1 << 12;
    localparam logic [32:0] M_Y_EN    = 33'd1 << 13;
    localparam logic [32:0] M_INCPC   = 33'd1 << 16;
    localparam logic [32:0] M_READ    = 33'd1 << 17;
    localparam logic [32:0] M_RAM_WE  = 33'd1 << 18;
    localparam logic [32:0] M_OUTPORT = 33'd1 << 19;
    localparam logic [32:0] M_CON_IN  = 33'd1 << 20;
    localparam logic [32:0] M_GRA     = 33'd1 << 21;
    localparam logic [32:0] M_GRB     = 33'd1 << 22;
    localparam logic [32:0] M_GRC     = 33'd1 << 23;
    localparam logic [32:0] M_R_IN    = 33'd1 << 24;
    localparam logic [32:0] M_R_OUT   = 33'd1 << 25;
    localparam logic [32:0] M_BA_OUT  = 33'd1 << 26;
    localparam logic [32:0] M_RUN     = 33'd1 << 32;

    logic [32:0] exp_q[$];
    logic [32:0] seq_q[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    int cyc_idx = 0;

    function automatic logic [32:0] opc(input logic [4:0] o);
        return {1'b0, o, 27'd0};
    endfunction

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    endtask

    // reference model: one entry per clock cycle of the instruction, fetch included
    task automatic step(input logic [32:0] v);
        seq_q.push_back(M_RUN | v);
    endtask

    task automatic build_seq(input logic [4:0] op, input logic con);
        seq_q.delete();
        step(M_PC_OUT | M_MAR_EN | M_INCPC | M_PC_EN);
        repeat (MW) step(M_READ | M_MDR_EN);
        step(M_MDR_OUT | M_IR_EN);
        if (op >= 3 && op <= 11) begin
            step(M_GRB | M_R_OUT | M_Y_EN);
            step(M_GRC | M_R_OUT | M_Z_EN | opc(op));
            step(M_ZLOW | M_GRA | M_R_IN);
        end else if (op >= 12 && op <= 14) begin
            step(M_GRB | M_R_OUT | M_Y_EN);
            step(M_C_OUT | M_Z_EN | opc(op));
            step(M_ZLOW | M_GRA | M_R_IN);
        end else if (op <= 2) begin
            step(M_GRB | M_BA_OUT | M_Y_EN);
            step(M_C_OUT | M_Z_EN | opc(5'd3));
            if (op == 1) step(M_ZLOW | M_GRA | M_R_IN);
            else step(M_ZLOW | M_MAR_EN);
            if (op == 0) begin
                repeat (MW) step(M_READ | M_MDR_EN);
                step(M_MDR_OUT | M_GRA | M_R_IN);
            end else if (op == 2) begin
                step(M_GRA | M_R_OUT | M_MDR_EN);
                step(M_RAM_WE);
            end
        end else if (op == 19) begin
            step(M_GRA | M_R_OUT | M_CON_IN);
            step(M_PC_OUT | M_Y_EN);
            step(M_C_OUT | M_Z_EN | opc(5'd19));
            step(con ? (M_ZLOW | M_PC_EN) : 33'd0);
        end else if (op == 20) step(M_GRA | M_R_OUT | M_PC_EN);
        else if (op == 22) step(M_INPORT | M_GRA | M_R_IN);
        else if (op == 23) step(M_GRA | M_R_OUT | M_OUTPORT);
        else if (op == 24) step(M_HI_OUT | M_GRA | M_R_IN);
        else if (op == 25) step(M_LO_OUT | M_GRA | M_R_IN);
        else step(33'd0);
    endtask

    // driver tasks: called just after a posedge; each pushed entry is consumed at the next negedge
    task automatic do_reset();
        clr = 1'b0;
        stop = 1'b0;
        repeat (2) begin
            exp_q.push_back('0);
            @(posedge Clock); #1;
        end
        clr = 1'b1;
        exp_q.push_back('0);
        @(posedge Clock); #1;
    endtask

    task automatic run_instr(input logic [4:0] op, input logic con, input logic stp);
        build_seq(op, con);
        IR = {op, 27'($urandom)};
        con_ff = con;
        stop = stp;
        foreach (seq_q[i]) exp_q.push_back(seq_q[i]);
        repeat (seq_q.size()) @(posedge Clock);
        #1;
        if (stp || op == 5'd27) begin
            repeat (3) begin
                exp_q.push_back('0);
                @(posedge Clock); #1;
            end
            do_reset();
        end
    endtask

    task automatic clr_mid_add();
        build_seq(5'd3, 1'b0);
        IR = {5'd3, 27'($urandom)};
        stop = 1'b0;
        for (int i = 0; i < MW + 3; i++) exp_q.push_back(seq_q[i]);
        repeat (MW + 3) @(posedge Clock);
        #2;
        check("mid_T4_before_clr", dut_vec, seq_q[MW + 3]);
        clr = 1'b0;
        #1;
        check("async_clr_zero", dut_vec, 33'd0);
        exp_q.push_back('0);
        @(posedge Clock); #1;
        exp_q.push_back('0);
        clr = 1'b1;
        @(posedge Clock); #1;
    endtask

    // scoreboard monitor
    always @(negedge Clock) begin
        if (exp_q.size() > 0) begin
            check($sformatf("cycle%0d", cyc_idx), dut_vec, exp_q.pop_front());
            cyc_idx++;
        end
    end

    initial begin
        #300000;
        chk_cnt++;
        $display("FAIL watchdog: time limit reached, %0d entries left", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        logic [4:0] rop;
        @(posedge Clock); #1;
        do_reset();
        run_instr(5'd3, 1'b0, 1'b0);   // add
        run_instr(5'd19, 1'b1, 1'b0);  // br taken
        run_instr(5'd19, 1'b0, 1'b0);  // br not taken
        run_instr(5'd0, 1'b0, 1'b0);   // ld
        run_instr(5'd2, 1'b0, 1'b0);   // st
        run_instr(5'd1, 1'b0, 1'b0);   // ldi
        run_instr(5'd12, 1'b0, 1'b0);  // addi
        run_instr(5'd20, 1'b0, 1'b0);  // jr
        run_instr(5'd22, 1'b0, 1'b0);  // in
        run_instr(5'd23, 1'b0, 1'b0);  // out
        run_instr(5'd24, 1'b0, 1'b0);  // mfhi
        run_instr(5'd25, 1'b0, 1'b0);  // mflo
        run_instr(5'd26, 1'b0, 1'b0);  // nop
        run_instr(5'd16, 1'b0, 1'b0);  // undefined
        clr_mid_add();
        run_instr(5'd11, 1'b0, 1'b0);
        run_instr(5'd3, 1'b0, 1'b1);   // add with stop
        run_instr(5'd27, 1'b0, 1'b0);  // halt
        run_instr(5'd2, 1'b1, 1'b1);   // st with stop
        for (int n = 0; n < 120; n++) begin
            rop = 5'($urandom_range(0, 31));
            run_instr(rop, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
        end
        repeat (2) @(posedge Clock);
        chk_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL queue_drain: got %0d entries left required 0", exp_q.size());
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
